axi_lite_arb2: RTL and testbench
================================

# axi_lite_arb2

Two-requester arbiter in front of the single AXI-lite-style register slave (4-bit address, 4-bit write data, 8-bit read data, AR/R/AW/W valid-ready channels, no B channel). Grants one complete transaction at a time, round-robin between requesters, and aborts transactions the slave never completes. Sits between the host-side requesters and the slave's `ms_*`/`sm_*` ports.

## Interface
- `ADDR_W`, 4, address width
- `WDATA_W`, 4, write data width
- `RDATA_W`, 8, read data width
- `TIMEOUT`, 64, stall cycles before abort; 0 disables the timeout
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `m_arvalid[i]`, `m_araddr[i]`, `m_rready[i]`  in  1/ADDR_W/1 per requester i∈{0,1}
- `m_awvalid[i]`, `m_awaddr[i]`, `m_wvalid[i]`, `m_wdata[i]`  in  1/ADDR_W/1/WDATA_W per requester
- `m_arready[i]`, `m_rvalid[i]`, `m_rdata[i]`, `m_awready[i]`, `m_wready[i]`  out  1/1/RDATA_W/1/1 per requester
- `ms_arvalid`, `ms_araddr`, `ms_rready`, `ms_awvalid`, `ms_awaddr`, `ms_wvalid`, `ms_wdata`  out  to slave
- `sm_arready`, `sm_rvalid`, `sm_rdata`, `sm_awready`, `sm_wready`  in  from slave
- `grant`  out  2  one-hot owner, 0 when idle
- `err_timeout`  out  1  sticky abort flag
- `err_clr`  in  1  clears `err_timeout`

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR.
- Request of i = `m_arvalid[i] | m_awvalid[i]`.
- IDLE: if any request, register grant; both requesting -> the one not equal to `last`. Granted requester with both valids -> read first (RD_ADDR), else WR.
- RD_ADDR: slave AR signals = granted requester's; `sm_arready` routed to `m_arready[g]`. AR handshake -> RD_DATA.
- RD_DATA: `sm_rvalid`/`sm_rdata` routed to granted requester, `m_rready[g]` to `ms_rready`. R handshake -> IDLE, `last` <= g.
- WR: AW and W passed through independently; `aw_done`/`w_done` flags set on each handshake; a completed channel's `ms_*valid` forced 0 thereafter. Both done -> IDLE, `last` <= g, flags cleared.
- Non-granted requester: all its ready/rvalid outputs 0; `m_rdata` of both = `sm_rdata` (don't-care unless rvalid).
- Timeout: counter resets on state entry and on any handshake, increments otherwise outside IDLE. Reaching TIMEOUT -> IDLE, `err_timeout` <= 1, `last` <= g (other requester wins next contest), flags cleared. No response generated to aborted requester.
- `err_clr` and timeout same cycle: set wins.

## Timing
- Reset: state IDLE, `grant`=0, `last`=1 (requester 0 wins first contest), flags/counter 0, `err_timeout`=0; all `ms_*valid`, `ms_rready`, `m_*ready`, `m_rvalid` = 0 the cycle after `rst` is high, including mid-transaction.
- Arbitration latency: request at cycle N -> `grant` and `ms_arvalid`/`ms_awvalid` high at N+1.
- Handshake paths are combinational through the registered grant (zero added latency per channel).
- Back-to-back: completion at cycle N -> IDLE at N+1 -> next grant at N+2 (one idle cycle minimum).
- Requester dropping valid while granted (protocol violation): passed through; recovery only via timeout.

## Structure
- Package `axi_arb_pkg`: state enum, width defaults, `TIMEOUT` default.
- Sub-module `rr_arb2`: 2-way round-robin picker (req[1:0], last -> one-hot grant), purely combinational; state, counter and routing in top.

## Test plan
- Single read: requester 0 reads addr 4'h3, slave returns 8'hA5 after 2-cycle arready delay -> `m_rdata[0]`=8'hA5 with `m_rvalid[0]`, `grant`=2'b01 from N+1 until R handshake.
- Contention: both assert `arvalid` same cycle after reset -> requester 0 served first, requester 1 granted two cycles after R handshake; repeat -> order 1 then 0.
- Split write: requester 1 writes addr 4'h7 data 4'h9, slave asserts `sm_wready` 3 cycles before `sm_awready` -> `ms_wvalid` drops after W handshake, return to IDLE only after AW; one transfer each.
- Read+write same requester: requester 0 asserts both -> read completes first, then write.
- Timeout: TIMEOUT=8, slave never asserts `sm_arready` -> IDLE after 8 stall cycles, `err_timeout`=1, competing requester 1 granted next; `err_clr` pulse -> 0.
- Reset mid-write: `rst` during WR with AW done -> all outputs 0 next cycle, new write afterwards issues both AW and W.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared definitions for the two-requester AXI-lite arbiter.
//   - arb_state_t : arbiter FSM state encoding
//   - *_DEF       : default widths and stall timeout used by axi_lite_arb2
package axi_arb_pkg;

    localparam int ADDR_W_DEF  = 4;
    localparam int WDATA_W_DEF = 4;
    localparam int RDATA_W_DEF = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_ADDR = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR      = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker, purely combinational.
//   req  : request vector, bit i = requester i wants the slave
//   last : index of the requester served most recently
//   gnt  : one-hot pick, 0 when nobody requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Only a tie needs the history bit: the requester that did not go last wins.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi_lite_arb2.sv
// Arbiter placing two AXI-lite-style requesters (AR/R/AW/W, no B) in front of
// one register slave. One complete transaction is granted at a time, ties go
// round-robin, and a transaction the slave stalls on for TIMEOUT cycles is
// abandoned with a sticky error flag.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   m_*             : per-requester channels, index i in {0,1}
//   ms_* / sm_*     : to / from the slave
//   grant           : one-hot owner, 0 while idle
//   err_timeout     : sticky abort flag, cleared by err_clr (a new abort wins)
//
// State      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no owner; pick a requester from the current requests
// ST_RD_ADDR | owner's AR channel connected to the slave
// ST_RD_DATA | owner's R channel connected to the slave
// ST_WR      | owner's AW and W connected; each closes on its own handshake
module axi_lite_arb2
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int WDATA_W = WDATA_W_DEF,
    parameter int RDATA_W = RDATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [1:0]                   m_arvalid,
    input  logic [1:0][ADDR_W-1:0]       m_araddr,
    input  logic [1:0]                   m_rready,
    input  logic [1:0]                   m_awvalid,
    input  logic [1:0][ADDR_W-1:0]       m_awaddr,
    input  logic [1:0]                   m_wvalid,
    input  logic [1:0][WDATA_W-1:0]      m_wdata,
    output logic [1:0]                   m_arready,
    output logic [1:0]                   m_rvalid,
    output logic [1:0][RDATA_W-1:0]      m_rdata,
    output logic [1:0]                   m_awready,
    output logic [1:0]                   m_wready,

    output logic                         ms_arvalid,
    output logic [ADDR_W-1:0]            ms_araddr,
    output logic                         ms_rready,
    output logic                         ms_awvalid,
    output logic [ADDR_W-1:0]            ms_awaddr,
    output logic                         ms_wvalid,
    output logic [WDATA_W-1:0]           ms_wdata,
    input  logic                         sm_arready,
    input  logic                         sm_rvalid,
    input  logic [RDATA_W-1:0]           sm_rdata,
    input  logic                         sm_awready,
    input  logic                         sm_wready,

    output logic [1:0]                   grant,
    output logic                         err_timeout,
    input  logic                         err_clr
);

    // Stall timer counts down from TIMEOUT-1; reaching zero on a stall cycle
    // means TIMEOUT consecutive cycles went by without progress.
    localparam int              TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    arb_state_t       state;
    logic             last;
    logic             aw_done;
    logic             w_done;
    logic [TMR_W-1:0] tmr;

    logic [1:0] req;
    logic [1:0] pick;
    logic       gsel;
    logic       st_rd_addr;
    logic       st_rd_data;
    logic       st_wr;
    logic       ar_hs;
    logic       r_hs;
    logic       aw_hs;
    logic       w_hs;
    logic       tmr_expired;
    logic       abort;

    assign req = m_arvalid | m_awvalid;

    rr_arb2 u_rr (
        .req  (req),
        .last (last),
        .gnt  (pick)
    );

    // grant is 0 in IDLE, so gsel only matters when every path below is
    // already gated off by state.
    assign gsel       = grant[1];
    assign st_rd_addr = (state == ST_RD_ADDR);
    assign st_rd_data = (state == ST_RD_DATA);
    assign st_wr      = (state == ST_WR);

    assign ms_arvalid = st_rd_addr & m_arvalid[gsel];
    assign ms_araddr  = m_araddr[gsel];
    assign ms_rready  = st_rd_data & m_rready[gsel];
    assign ms_awvalid = st_wr & ~aw_done & m_awvalid[gsel];
    assign ms_awaddr  = m_awaddr[gsel];
    assign ms_wvalid  = st_wr & ~w_done & m_wvalid[gsel];
    assign ms_wdata   = m_wdata[gsel];

    assign m_arready  = grant & {2{st_rd_addr & sm_arready}};
    assign m_rvalid   = grant & {2{st_rd_data & sm_rvalid}};
    assign m_awready  = grant & {2{st_wr & ~aw_done & sm_awready}};
    assign m_wready   = grant & {2{st_wr & ~w_done & sm_wready}};
    assign m_rdata    = {2{sm_rdata}};

    assign ar_hs = ms_arvalid & sm_arready;
    assign r_hs  = ms_rready & sm_rvalid;
    assign aw_hs = ms_awvalid & sm_awready;
    assign w_hs  = ms_wvalid & sm_wready;

    assign tmr_expired = (TIMEOUT != 0) && (tmr == '0);
    assign abort       = (state != ST_IDLE) && !(ar_hs | r_hs | aw_hs | w_hs) && tmr_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant       <= 2'b00;
            last        <= 1'b1;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            tmr         <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (err_clr) begin
                err_timeout <= 1'b0;
            end

            if (abort) begin
                // The aborted owner counts as served so the other side wins next.
                state       <= ST_IDLE;
                grant       <= 2'b00;
                last        <= gsel;
                aw_done     <= 1'b0;
                w_done      <= 1'b0;
                err_timeout <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        tmr <= TMR_LOAD;
                        if (|req) begin
                            grant <= pick;
                            // A requester with both valids is served read first.
                            state <= m_arvalid[pick[1]] ? ST_RD_ADDR : ST_WR;
                        end
                    end
                    ST_RD_ADDR: begin
                        if (ar_hs) begin
                            state <= ST_RD_DATA;
                            tmr   <= TMR_LOAD;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    ST_RD_DATA: begin
                        if (r_hs) begin
                            state <= ST_IDLE;
                            grant <= 2'b00;
                            last  <= gsel;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    ST_WR: begin
                        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                            state   <= ST_IDLE;
                            grant   <= 2'b00;
                            last    <= gsel;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                        end else begin
                            if (aw_hs) aw_done <= 1'b1;
                            if (w_hs)  w_done  <= 1'b1;
                            tmr <= (aw_hs | w_hs) ? TMR_LOAD : tmr - 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        grant <= 2'b00;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_arb2.sv
module tb_axi_lite_arb2;

    localparam int AW = 4;
    localparam int WW = 4;
    localparam int RW = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          m_arvalid;
    logic [1:0][AW-1:0]  m_araddr;
    logic [1:0]          m_rready;
    logic [1:0]          m_awvalid;
    logic [1:0][AW-1:0]  m_awaddr;
    logic [1:0]          m_wvalid;
    logic [1:0][WW-1:0]  m_wdata;
    logic [1:0]          m_arready;
    logic [1:0]          m_rvalid;
    logic [1:0][RW-1:0]  m_rdata;
    logic [1:0]          m_awready;
    logic [1:0]          m_wready;
    logic                ms_arvalid;
    logic [AW-1:0]       ms_araddr;
    logic                ms_rready;
    logic                ms_awvalid;
    logic [AW-1:0]       ms_awaddr;
    logic                ms_wvalid;
    logic [WW-1:0]       ms_wdata;
    logic                sm_arready;
    logic                sm_rvalid;
    logic [RW-1:0]       sm_rdata;
    logic                sm_awready;
    logic                sm_wready;
    logic [1:0]          grant;
    logic                err_timeout;
    logic                err_clr;

    axi_lite_arb2 #(
        .ADDR_W  (AW),
        .WDATA_W (WW),
        .RDATA_W (RW),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_arvalid   (m_arvalid),
        .m_araddr    (m_araddr),
        .m_rready    (m_rready),
        .m_awvalid   (m_awvalid),
        .m_awaddr    (m_awaddr),
        .m_wvalid    (m_wvalid),
        .m_wdata     (m_wdata),
        .m_arready   (m_arready),
        .m_rvalid    (m_rvalid),
        .m_rdata     (m_rdata),
        .m_awready   (m_awready),
        .m_wready    (m_wready),
        .ms_arvalid  (ms_arvalid),
        .ms_araddr   (ms_araddr),
        .ms_rready   (ms_rready),
        .ms_awvalid  (ms_awvalid),
        .ms_awaddr   (ms_awaddr),
        .ms_wvalid   (ms_wvalid),
        .ms_wdata    (ms_wdata),
        .sm_arready  (sm_arready),
        .sm_rvalid   (sm_rvalid),
        .sm_rdata    (sm_rdata),
        .sm_awready  (sm_awready),
        .sm_wready   (sm_wready),
        .grant       (grant),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // slave-side handshake counters, sampled on the active edge
    int aw_hs_n = 0;
    int w_hs_n  = 0;
    always @(posedge clk) begin
        if (ms_awvalid && sm_awready) aw_hs_n++;
        if (ms_wvalid && sm_wready)   w_hs_n++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_arvalid  = 2'b00;
        m_awvalid  = 2'b00;
        m_wvalid   = 2'b00;
        m_rready   = 2'b00;
        sm_arready = 1'b0;
        sm_rvalid  = 1'b0;
        sm_awready = 1'b0;
        sm_wready  = 1'b0;
        err_clr    = 1'b0;
    endtask

    // s  = {sm_arready, sm_rvalid, sm_awready, sm_wready}
    // ms = {ms_arvalid, ms_rready, ms_awvalid, ms_wvalid}
    // m  = {m_arready, m_rvalid, m_awready, m_wready}
    typedef struct packed {
        logic       rst;
        logic [1:0] arv;
        logic [1:0] awv;
        logic [1:0] wv;
        logic [1:0] rr;
        logic [3:0] s;
        logic [1:0] g;
        logic [3:0] ms;
        logic [7:0] m;
        logic [3:0] addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [1:0] arv, logic [1:0] awv, logic [1:0] wv,
                                logic [1:0] rr, logic [3:0] s, logic [1:0] g, logic [3:0] ms,
                                logic [7:0] m, logic [3:0] addr);
        vec_t v;
        v.rst = r; v.arv = arv; v.awv = awv; v.wv = wv; v.rr = rr; v.s = s;
        v.g = g; v.ms = ms; v.m = m; v.addr = addr;
        return v;
    endfunction

    int aw0;
    int w0;
    int stall_bad;

    initial begin
        // single read by requester 0, arready two cycles late
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01, 4'b0000, 2'b00, 4'b0000, 8'b00000000, 4'h0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01, 4'b0000, 2'b01, 4'b1000, 8'b00000000, 4'h3));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01, 4'b0000, 2'b01, 4'b1000, 8'b00000000, 4'h3));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01, 4'b1000, 2'b01, 4'b1000, 8'b01000000, 4'h3));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0100, 2'b01, 4'b0100, 8'b00010000, 4'h0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 2'b00, 4'b0000, 8'b00000000, 4'h0));
        // reset, then both requesters read together: 0, then 1, then 0 again
        tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b11, 4'b0000, 2'b00, 4'b0000, 8'b00000000, 4'h0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b11, 4'b0000, 2'b00, 4'b0000, 8'b00000000, 4'h0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b11, 4'b1000, 2'b01, 4'b1000, 8'b01000000, 4'h3));
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 2'b11, 4'b0100, 2'b01, 4'b0100, 8'b00010000, 4'h0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b11, 4'b0000, 2'b00, 4'b0000, 8'b00000000, 4'h0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b11, 4'b1000, 2'b10, 4'b1000, 8'b10000000, 4'h6));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b11, 4'b0100, 2'b10, 4'b0100, 8'b00100000, 4'h0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b11, 4'b0000, 2'b00, 4'b0000, 8'b00000000, 4'h0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b11, 4'b1000, 2'b01, 4'b1000, 8'b01000000, 4'h3));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b11, 4'b0100, 2'b01, 4'b0100, 8'b00010000, 4'h0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b11, 4'b0000, 2'b00, 4'b0000, 8'b00000000, 4'h0));
        // requester 0 with read and write pending: read first, then write
        tbl.push_back(mk(0, 2'b01, 2'b01, 2'b01, 2'b01, 4'b0000, 2'b00, 4'b0000, 8'b00000000, 4'h0));
        tbl.push_back(mk(0, 2'b01, 2'b01, 2'b01, 2'b01, 4'b1000, 2'b01, 4'b1000, 8'b01000000, 4'h3));
        tbl.push_back(mk(0, 2'b00, 2'b01, 2'b01, 2'b01, 4'b0100, 2'b01, 4'b0100, 8'b00010000, 4'h0));
        tbl.push_back(mk(0, 2'b00, 2'b01, 2'b01, 2'b01, 4'b0000, 2'b00, 4'b0000, 8'b00000000, 4'h0));
        tbl.push_back(mk(0, 2'b00, 2'b01, 2'b01, 2'b01, 4'b0011, 2'b01, 4'b0011, 8'b00000101, 4'h2));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 8'b00000000, 4'h0));

        m_araddr = {4'h6, 4'h3};
        m_awaddr = {4'h7, 4'h2};
        m_wdata  = {4'h9, 4'h5};
        sm_rdata = 8'hA5;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_outs",
              32'({grant, ms_arvalid, ms_rready, ms_awvalid, ms_wvalid,
                   m_arready, m_rvalid, m_awready, m_wready, err_timeout}), 32'h0);

        for (int k = 0; k < tbl.size(); k++) begin
            rst       = tbl[k].rst;
            m_arvalid = tbl[k].arv;
            m_awvalid = tbl[k].awv;
            m_wvalid  = tbl[k].wv;
            m_rready  = tbl[k].rr;
            {sm_arready, sm_rvalid, sm_awready, sm_wready} = tbl[k].s;
            #1;
            check($sformatf("row%0d_grant", k), 32'(grant), 32'(tbl[k].g));
            check($sformatf("row%0d_ms", k),
                  32'({ms_arvalid, ms_rready, ms_awvalid, ms_wvalid}), 32'(tbl[k].ms));
            check($sformatf("row%0d_m", k),
                  32'({m_arready, m_rvalid, m_awready, m_wready}), 32'(tbl[k].m));
            if (tbl[k].ms[3])
                check($sformatf("row%0d_araddr", k), 32'(ms_araddr), 32'(tbl[k].addr));
            if (tbl[k].ms[1])
                check($sformatf("row%0d_awaddr", k), 32'(ms_awaddr), 32'(tbl[k].addr));
            if (tbl[k].m[5:4] != 2'b00)
                check($sformatf("row%0d_rdata", k),
                      32'(m_rdata[tbl[k].m[5] ? 1 : 0]), 32'h0000_00A5);
            tick();
        end
        rst = 1'b0;
        idle_inputs();

        // split write by requester 1: W accepted three cycles before AW
        aw0 = aw_hs_n;
        w0  = w_hs_n;
        m_awvalid = 2'b10;
        m_wvalid  = 2'b10;
        tick();
        sm_wready = 1'b1;
        #1;
        check("sw_grant", 32'(grant), 32'h2);
        check("sw_awaddr", 32'(ms_awaddr), 32'h7);
        check("sw_wdata", 32'(ms_wdata), 32'h9);
        check("sw_first", 32'({ms_awvalid, ms_wvalid, m_wready}), 32'b1110);
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("sw_wait%0d", i),
                  32'({grant, ms_awvalid, ms_wvalid, m_wready}), 32'b10_1_0_00);
            tick();
        end
        sm_awready = 1'b1;
        #1;
        check("sw_aw", 32'({ms_awvalid, m_awready}), 32'b110);
        tick();
        idle_inputs();
        #1;
        check("sw_idle", 32'(grant), 32'h0);
        check("sw_aw_count", 32'(aw_hs_n - aw0), 32'd1);
        check("sw_w_count", 32'(w_hs_n - w0), 32'd1);

        // timeout: slave ignores requester 0's read, requester 1 waits with a write
        m_arvalid = 2'b01;
        m_rready  = 2'b01;
        m_awvalid = 2'b10;
        m_wvalid  = 2'b10;
        tick();
        stall_bad = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (grant != 2'b01 || !ms_arvalid || err_timeout) stall_bad++;
            tick();
        end
        check("to_stall_cycles", 32'(stall_bad), 32'd0);
        check("to_abort", 32'({grant, err_timeout, m_rvalid}), 32'b00_1_00);
        tick();
        check("to_next_grant", 32'({grant, ms_awvalid, ms_arvalid}), 32'b10_1_0);
        sm_awready = 1'b1;
        sm_wready  = 1'b1;
        tick();
        idle_inputs();
        tick();
        check("to_sticky", 32'(err_timeout), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        check("to_clr", 32'(err_timeout), 32'h0);

        // reset in the middle of a write whose AW already completed
        m_awvalid = 2'b01;
        m_wvalid  = 2'b01;
        tick();
        sm_awready = 1'b1;
        #1;
        check("rw_aw", 32'(m_awready), 32'h1);
        tick();
        sm_awready = 1'b0;
        #1;
        check("rw_aw_done", 32'({ms_awvalid, ms_wvalid}), 32'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rw_rst_outs",
              32'({grant, ms_arvalid, ms_rready, ms_awvalid, ms_wvalid,
                   m_arready, m_rvalid, m_awready, m_wready}), 32'h0);
        aw0 = aw_hs_n;
        w0  = w_hs_n;
        tick();
        check("rw_regrant", 32'({grant, ms_awvalid, ms_wvalid}), 32'b01_1_1);
        sm_awready = 1'b1;
        sm_wready  = 1'b1;
        tick();
        idle_inputs();
        #1;
        check("rw_done", 32'({grant, aw_hs_n - aw0 == 1, w_hs_n - w0 == 1}), 32'b00_1_1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
